iopmp_seq_checker: RTL

//  Walks the IOPMP entry table one entry per cycle for each incoming DMA address request.

---
 rtl/iopmp_pkg.sv | 22 ++
 rtl/pmp_entry.sv | 30 +++
 rtl/iopmp_seq_checker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/iopmp_pkg.sv
// Shared IOPMP types: entry address modes, permission bits and sequential checker FSM states.
package iopmp_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } iopmp_addr_mode_t;

  typedef struct packed {
    logic w;
    logic r;
  } iopmp_perm_t;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    RESP
  } iopmp_chk_state_e;

endpackage

// File: rtl/pmp_entry.sv
// Combinational address matcher for a single IOPMP entry (OFF/TOR/NA4/NAPOT).
module pmp_entry
  import iopmp_pkg::*;
#(
  parameter int unsigned PLEN    = 56,
  parameter int unsigned PMP_LEN = 54
) (
  input  logic [PLEN-1:0]    addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_prev_i,
  input  iopmp_addr_mode_t   mode_i,
  output logic               match_o
);

  logic [PMP_LEN-1:0] napot_mask;

  always_comb begin
    // Trailing ones plus the first zero above them select the NAPOT region size.
    napot_mask = conf_addr_i ^ (conf_addr_i + 1'b1);
    match_o    = 1'b0;
    unique case (mode_i)
      OFF:   match_o = 1'b0;
      TOR:   match_o = (addr_i >= {conf_addr_prev_i, 2'b00}) && (addr_i < {conf_addr_i, 2'b00});
      NA4:   match_o = (addr_i[PLEN-1:2] == conf_addr_i);
      NAPOT: match_o = ((addr_i[PLEN-1:2] ^ conf_addr_i) & ~napot_mask) == '0;
      default: match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/iopmp_seq_checker.sv
// Sequential IOPMP checker: walks the entry table one entry per cycle through a single
// shared matcher; the lowest-index match decides allow/deny.
module iopmp_seq_checker
  import iopmp_pkg::*;
#(
  parameter int unsigned PLEN          = 56,
  parameter int unsigned PMP_LEN       = 54,
  parameter int unsigned NR_ENTRIES    = 16,
  parameter bit          DEFAULT_ALLOW = 1'b0,
  localparam int unsigned IdxW         = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [PLEN-1:0]               req_addr_i,
  input  logic                          req_read_i,
  input  logic                          req_write_i,
  input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
  input  logic [NR_ENTRIES*2-1:0]       conf_mode_i,
  input  logic [NR_ENTRIES*2-1:0]       conf_perm_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          rsp_allow_o,
  output logic                          rsp_hit_o,
  output logic [IdxW-1:0]               rsp_entry_o
);

  iopmp_chk_state_e state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [PLEN-1:0]  addr_q, addr_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic             allow_q, allow_d, hit_q, hit_d;
  logic [IdxW-1:0]  entry_q, entry_d;

  logic [PMP_LEN-1:0] addr_arr [NR_ENTRIES];
  logic [1:0]         mode_arr [NR_ENTRIES];
  logic [1:0]         perm_arr [NR_ENTRIES];

  for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_unpack
    assign addr_arr[i] = conf_addr_i[i*PMP_LEN +: PMP_LEN];
    assign mode_arr[i] = conf_mode_i[i*2 +: 2];
    assign perm_arr[i] = conf_perm_i[i*2 +: 2];
  end

  logic [PMP_LEN-1:0] cur_addr, prev_addr;
  iopmp_addr_mode_t   cur_mode;
  iopmp_perm_t        cur_perm;
  logic               match, last;

  always_comb begin
    cur_addr  = addr_arr[idx_q];
    prev_addr = (idx_q == '0) ? '0 : addr_arr[idx_q - 1'b1];
    cur_mode  = iopmp_addr_mode_t'(mode_arr[idx_q]);
    cur_perm  = iopmp_perm_t'(perm_arr[idx_q]);
    last      = (idx_q == IdxW'(NR_ENTRIES - 1));
  end

  pmp_entry #(
    .PLEN    (PLEN),
    .PMP_LEN (PMP_LEN)
  ) u_pmp_entry (
    .addr_i           (addr_q),
    .conf_addr_i      (cur_addr),
    .conf_addr_prev_i (prev_addr),
    .mode_i           (cur_mode),
    .match_o          (match)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      allow_q <= 1'b0;
      hit_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      allow_q <= allow_d;
      hit_q   <= hit_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    allow_d = allow_q;
    hit_d   = hit_q;
    entry_d = entry_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          rd_d    = req_read_i;
          wr_d    = req_write_i;
          idx_d   = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (match) begin
          hit_d   = 1'b1;
          entry_d = idx_q;
          allow_d = (!rd_q || cur_perm.r) && (!wr_q || cur_perm.w);
          state_d = RESP;
        end else if (last) begin
          hit_d   = 1'b0;
          entry_d = '0;
          allow_d = DEFAULT_ALLOW;
          state_d = RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    rsp_allow_o = allow_q;
    rsp_hit_o   = hit_q;
    rsp_entry_o = entry_q;
  end

endmodule
